// File: rtl/dma_sram_cache_pkg.sv
// -----------------------------------------------------------------------------
// dma_sram_cache_pkg
// Shared constants and types for the DMA SRAM cache flow controller.
//   DATA_WIDTH / ADDR_WIDTH : SRAM word and address widths (256 x 64)
//   DEPTH / LEVEL_WIDTH     : SRAM depth and width of the occupancy count
//   OUT_BUF_DEPTH           : entries in the read-side output buffer
//   SRAM_RD_LATENCY         : SRAM read pipeline stages (address, data)
// -----------------------------------------------------------------------------
package dma_sram_cache_pkg;

    localparam int DATA_WIDTH      = 64;
    localparam int ADDR_WIDTH      = 8;
    localparam int DEPTH           = 256;
    localparam int LEVEL_WIDTH     = 9;
    localparam int OUT_BUF_DEPTH   = 3;
    localparam int SRAM_RD_LATENCY = 2;

    // Occupancy of one stage of the SRAM read pipeline.
    typedef enum logic {
        STG_IDLE = 1'b0,
        STG_BUSY = 1'b1
    } rd_stage_e;

    // Modulo-OUT_BUF_DEPTH increment for output buffer indices.
    function automatic logic [1:0] buf_idx_inc(input logic [1:0] idx);
        return (idx == 2'(OUT_BUF_DEPTH - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/dma_sram_cache_out_buf.sv
// -----------------------------------------------------------------------------
// dma_sram_cache_out_buf
// Small FIFO that catches words leaving the SRAM read pipeline and presents
// them to the consumer with valid/ready. The controller's credit scheme keeps
// it from ever being written while full.
// Ports:
//   clk_i      clock
//   flush_i    synchronous clear (reset or flush), wins over push/pop
//   wr_en_i    write strobe from the read pipeline
//   wr_data_i  word from the SRAM
//   rd_valid_o head entry valid
//   rd_ready_i consumer accepts head entry
//   rd_data_o  head entry
//   count_o    number of stored entries (0..3)
// -----------------------------------------------------------------------------
module dma_sram_cache_out_buf #(
    parameter int DATA_WIDTH = dma_sram_cache_pkg::DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [1:0]            count_o
);
    import dma_sram_cache_pkg::*;

    logic [DATA_WIDTH-1:0] mem_q [OUT_BUF_DEPTH];
    logic [1:0]            head_q, tail_q, count_q, count_d;
    logic                  push, pop;

    assign push       = wr_en_i & ~flush_i;
    assign pop        = rd_valid_o & rd_ready_i & ~flush_i;
    assign rd_valid_o = (count_q != 2'd0);
    assign rd_data_o  = mem_q[head_q];
    assign count_o    = count_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            count_q <= 2'd0;
        end else begin
            if (push) tail_q <= buf_idx_inc(tail_q);
            if (pop)  head_q <= buf_idx_inc(head_q);
            count_q <= count_d;
        end
    end

    // Data storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[tail_q] <= wr_data_i;
    end

endmodule

// File: rtl/dma_sram_cache_ctrl.sv
// -----------------------------------------------------------------------------
// dma_sram_cache_ctrl
// Flow controller for the DMA channel's 256 x 64 two-port SRAM cache. Presents
// a valid/ready FIFO to the DMA read engine (WR_*) and write engine (RD_*),
// drives the SRAM write/read ports, and hides the SRAM's two-cycle read
// latency behind a 3-entry output buffer.
// Ports:
//   CLK, SRST                 clock, synchronous active-high reset
//   WR_VALID/WR_READY/WR_DATA producer handshake
//   RD_VALID/RD_READY/RD_DATA consumer handshake
//   FLUSH                     synchronous discard of all contents
//   LEVEL                     words accepted and not yet popped (0..259)
//   SRAM_*                    connections to the SRAM instance above
// Optional build macro DMA_SRAM_CACHE_CTRL_WATERMARK_EN adds AF_THRESH /
// AE_THRESH parameters and registered ALMOST_FULL / ALMOST_EMPTY outputs.
// -----------------------------------------------------------------------------
module dma_sram_cache_ctrl #(
    parameter int DATA_WIDTH = dma_sram_cache_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = dma_sram_cache_pkg::ADDR_WIDTH
`ifdef DMA_SRAM_CACHE_CTRL_WATERMARK_EN
   ,parameter int AF_THRESH  = 240,
    parameter int AE_THRESH  = 8
`endif
) (
    input  logic                  CLK,
    input  logic                  SRST,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    input  logic                  FLUSH,
    output logic [ADDR_WIDTH:0]   LEVEL,
`ifdef DMA_SRAM_CACHE_CTRL_WATERMARK_EN
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
`endif
    output logic [DATA_WIDTH-1:0] SRAM_W_DATA,
    output logic [ADDR_WIDTH-1:0] SRAM_W_ADDR,
    output logic                  SRAM_W_EN,
    output logic [ADDR_WIDTH-1:0] SRAM_R_ADDR,
    output logic                  SRAM_R_EN,
    output logic                  SRAM_R_DATA_EN,
    input  logic [DATA_WIDTH-1:0] SRAM_R_DATA
);
    import dma_sram_cache_pkg::*;

    localparam logic [ADDR_WIDTH:0]   RAM_FULL  = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;
    logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
    rd_stage_e             rd_pipe_q [SRAM_RD_LATENCY];
    logic                  clear, push, issue, pop, buf_valid;
    logic [1:0]            inflight, buf_count;
    logic [2:0]            credit_used;

    assign clear    = FLUSH | SRST;
    assign WR_READY = (ram_count_q != RAM_FULL) & ~clear;
    assign push     = WR_VALID & WR_READY;
    assign pop      = buf_valid & RD_READY;

    assign inflight = 2'(rd_pipe_q[0] == STG_BUSY) + 2'(rd_pipe_q[1] == STG_BUSY);

    // A word leaving the buffer this cycle frees its slot for a new issue in
    // the same cycle; without that a steady stream would bubble every 4th cycle.
    assign credit_used = 3'(inflight) + 3'(buf_count) - 3'(pop);
    assign issue       = (ram_count_q != '0) & (credit_used < 3'(OUT_BUF_DEPTH)) & ~clear;

    assign SRAM_W_EN      = push;
    assign SRAM_W_ADDR    = wptr_q;
    assign SRAM_W_DATA    = WR_DATA;
    assign SRAM_R_EN      = issue;
    assign SRAM_R_ADDR    = rptr_q;
    assign SRAM_R_DATA_EN = (rd_pipe_q[0] == STG_BUSY);

    always_comb begin
        ram_count_d = ram_count_q;
        if (push && !issue) begin
            ram_count_d = ram_count_q + CNT_ONE;
        end else if (!push && issue) begin
            ram_count_d = ram_count_q - CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            ram_count_q  <= '0;
            rd_pipe_q[0] <= STG_IDLE;
            rd_pipe_q[1] <= STG_IDLE;
        end else begin
            if (push)  wptr_q <= wptr_q + PTR_ONE;
            if (issue) rptr_q <= rptr_q + PTR_ONE;
            ram_count_q  <= ram_count_d;
            rd_pipe_q[0] <= issue ? STG_BUSY : STG_IDLE;
            rd_pipe_q[1] <= rd_pipe_q[0];
        end
    end

    dma_sram_cache_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk_i      (CLK),
        .flush_i    (clear),
        .wr_en_i    (rd_pipe_q[1] == STG_BUSY),
        .wr_data_i  (SRAM_R_DATA),
        .rd_valid_o (buf_valid),
        .rd_ready_i (RD_READY),
        .rd_data_o  (RD_DATA),
        .count_o    (buf_count)
    );

    assign RD_VALID = buf_valid;
    assign LEVEL    = ram_count_q + (ADDR_WIDTH+1)'(inflight) + (ADDR_WIDTH+1)'(buf_count);

`ifdef DMA_SRAM_CACHE_CTRL_WATERMARK_EN
    logic almost_full_q, almost_empty_q;

    always_ff @(posedge CLK) begin
        if (SRST) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= (ram_count_q >= (ADDR_WIDTH+1)'(AF_THRESH));
            almost_empty_q <= (LEVEL <= (ADDR_WIDTH+1)'(AE_THRESH));
        end
    end

    assign ALMOST_FULL  = almost_full_q;
    assign ALMOST_EMPTY = almost_empty_q;
`endif

endmodule

// File: tb/tb_dma_sram_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dma_sram_cache_ctrl
// Self-checking bench for dma_sram_cache_ctrl with a behavioural SRAM model.
// Expected words are queued when a push is accepted and compared when the
// consumer pops them.
// -----------------------------------------------------------------------------
module tb_dma_sram_cache_ctrl;
    localparam int DW = 64;
    localparam int AW = 8;

    logic          CLK = 1'b0;
    logic          SRST, WR_VALID, RD_READY, FLUSH;
    logic [DW-1:0] WR_DATA;
    logic          WR_READY, RD_VALID;
    logic [DW-1:0] RD_DATA;
    logic [AW:0]   LEVEL;
    logic [DW-1:0] SRAM_W_DATA, SRAM_R_DATA;
    logic [AW-1:0] SRAM_W_ADDR, SRAM_R_ADDR;
    logic          SRAM_W_EN, SRAM_R_EN, SRAM_R_DATA_EN;
`ifdef DMA_SRAM_CACHE_CTRL_WATERMARK_EN
    logic          almost_full, almost_empty;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    logic [DW-1:0] sb [$];

    always #5 CLK = ~CLK;

    dma_sram_cache_ctrl dut (
        .CLK            (CLK),
        .SRST           (SRST),
        .WR_VALID       (WR_VALID),
        .WR_READY       (WR_READY),
        .WR_DATA        (WR_DATA),
        .RD_VALID       (RD_VALID),
        .RD_READY       (RD_READY),
        .RD_DATA        (RD_DATA),
        .FLUSH          (FLUSH),
        .LEVEL          (LEVEL),
`ifdef DMA_SRAM_CACHE_CTRL_WATERMARK_EN
        .ALMOST_FULL    (almost_full),
        .ALMOST_EMPTY   (almost_empty),
`endif
        .SRAM_W_DATA    (SRAM_W_DATA),
        .SRAM_W_ADDR    (SRAM_W_ADDR),
        .SRAM_W_EN      (SRAM_W_EN),
        .SRAM_R_ADDR    (SRAM_R_ADDR),
        .SRAM_R_EN      (SRAM_R_EN),
        .SRAM_R_DATA_EN (SRAM_R_DATA_EN),
        .SRAM_R_DATA    (SRAM_R_DATA)
    );

    // Two-port SRAM: address registered on R_EN, output register loaded on R_DATA_EN.
    logic [DW-1:0] sram_mem [256];
    logic [AW-1:0] sram_raddr_q;
    always @(posedge CLK) begin
        if (SRAM_W_EN)      sram_mem[SRAM_W_ADDR] <= SRAM_W_DATA;
        if (SRAM_R_EN)      sram_raddr_q          <= SRAM_R_ADDR;
        if (SRAM_R_DATA_EN) SRAM_R_DATA           <= sram_mem[sram_raddr_q];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive inputs after the falling edge, sample just after.
    task automatic drive_cycle(input logic wv, input logic [DW-1:0] wd, input logic rr,
                               input logic fl, output logic pushed, output logic popped,
                               output logic [DW-1:0] rdata);
        @(negedge CLK);
        WR_VALID = wv;
        WR_DATA  = wd;
        RD_READY = rr;
        FLUSH    = fl;
        #1;
        pushed = wv & WR_READY;
        popped = RD_VALID & rr;
        rdata  = RD_DATA;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        SRST = 1'b1; WR_VALID = 1'b0; RD_READY = 1'b0; FLUSH = 1'b0; WR_DATA = '0;
        repeat (2) @(negedge CLK);
        #1;
        tests_run++;
        if (WR_READY !== 1'b0) begin
            tests_failed++; $display("FAIL reset_wr_ready: got %b, required 0", WR_READY);
        end
        tests_run++;
        if ({RD_VALID, SRAM_W_EN, SRAM_R_EN, SRAM_R_DATA_EN} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_strobes: got rdv/wen/ren/rden=%b, required 0000",
                     {RD_VALID, SRAM_W_EN, SRAM_R_EN, SRAM_R_DATA_EN});
        end
        tests_run++;
        if (LEVEL !== '0) begin
            tests_failed++; $display("FAIL reset_level: got %0d, required 0", LEVEL);
        end
        tests_run++;
        if (SRAM_W_ADDR !== '0 || SRAM_R_ADDR !== '0) begin
            tests_failed++;
            $display("FAIL reset_addr: got w=%0d r=%0d, required 0 0", SRAM_W_ADDR, SRAM_R_ADDR);
        end
        @(negedge CLK);
        SRST = 1'b0;
        #1;
        tests_run++;
        if (WR_READY !== 1'b1 || RD_VALID !== 1'b0 || LEVEL !== '0) begin
            tests_failed++;
            $display("FAIL reset_release: got wr_ready=%b rd_valid=%b level=%0d, required 1 0 0",
                     WR_READY, RD_VALID, LEVEL);
        end
    endtask

    task automatic test_single();
        logic          pushed, popped;
        logic [DW-1:0] rdata, exp_w;
        logic [DW-1:0] word = 64'h0123_4567_89AB_CDEF;
        int            t_valid = -1;
        drive_cycle(1'b1, word, 1'b1, 1'b0, pushed, popped, rdata);
        tests_run++;
        if (pushed !== 1'b1 || SRAM_W_EN !== 1'b1 || SRAM_W_ADDR !== '0 || SRAM_W_DATA !== word) begin
            tests_failed++;
            $display("FAIL single_write: got push=%b wen=%b waddr=%0d wdata=%h, required 1 1 0 %h",
                     pushed, SRAM_W_EN, SRAM_W_ADDR, SRAM_W_DATA, word);
        end
        if (pushed) sb.push_back(word);
        for (int k = 1; k <= 8; k++) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0, pushed, popped, rdata);
            if (k == 1) begin
                tests_run++;
                if (SRAM_R_EN !== 1'b1 || LEVEL !== 9'd1) begin
                    tests_failed++;
                    $display("FAIL single_issue: got ren=%b level=%0d at t+1, required 1 1", SRAM_R_EN, LEVEL);
                end
            end
            if (k == 2) begin
                tests_run++;
                if (SRAM_R_DATA_EN !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL single_rden: got %b at t+2, required 1", SRAM_R_DATA_EN);
                end
            end
            if (popped) begin
                if (t_valid < 0) t_valid = k;
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++; $display("FAIL single_data: got extra word %h, required none", rdata);
                end else begin
                    exp_w = sb.pop_front();
                    if (rdata !== exp_w) begin
                        tests_failed++; $display("FAIL single_data: got %h, required %h", rdata, exp_w);
                    end
                end
            end
        end
        tests_run++;
        if (t_valid != 4) begin
            tests_failed++; $display("FAIL single_latency: RD_VALID at t+%0d, required t+4", t_valid);
        end
        tests_run++;
        if (LEVEL !== '0 || RD_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_level_after: got level=%0d rd_valid=%b, required 0 0", LEVEL, RD_VALID);
        end
    endtask

    task automatic test_stream();
        logic          pushed, popped, started = 1'b0;
        logic [DW-1:0] rdata, exp_w, wd;
        int n_push = 0, n_pop = 0, bubbles = 0, max_level = 0, cyc = 0;
        while (n_pop < 1000 && cyc < 1200) begin
            wd = 64'h1000_0000_0000_0000 + DW'(n_push);
            drive_cycle(n_push < 1000, wd, 1'b1, 1'b0, pushed, popped, rdata);
            cyc++;
            if (int'(LEVEL) > max_level) max_level = int'(LEVEL);
            if (pushed) begin sb.push_back(wd); n_push++; end
            if (started && !popped) bubbles++;
            if (popped) begin
                started = 1'b1;
                n_pop++;
                tests_run++;
                exp_w = (sb.size() != 0) ? sb.pop_front() : 'x;
                if (rdata !== exp_w) begin
                    tests_failed++; $display("FAIL stream_data: word %0d got %h, required %h", n_pop, rdata, exp_w);
                end
            end
        end
        tests_run++;
        if (n_pop != 1000) begin
            tests_failed++; $display("FAIL stream_count: got %0d words in %0d cycles, required 1000", n_pop, cyc);
        end
        tests_run++;
        if (bubbles != 0) begin
            tests_failed++; $display("FAIL stream_bubbles: got %0d idle cycles, required 0", bubbles);
        end
        tests_run++;
        if (max_level > 5) begin
            tests_failed++; $display("FAIL stream_level: got max %0d, required <= 5", max_level);
        end
    endtask

    task automatic test_fill();
        logic          pushed, popped;
        logic [DW-1:0] rdata, exp_w, wd;
        int n_push = 0, ready_at = -1, cyc = 0;
        for (int i = 0; i < 300; i++) begin
            wd = 64'h2000_0000_0000_0000 + DW'(i);
            drive_cycle(1'b1, wd, 1'b0, 1'b0, pushed, popped, rdata);
            if (pushed) begin sb.push_back(wd); n_push++; end
        end
        tests_run++;
        if (n_push != 259) begin
            tests_failed++; $display("FAIL fill_count: got %0d accepted, required 259", n_push);
        end
        tests_run++;
        if (WR_READY !== 1'b0 || LEVEL !== 9'd259 || RD_VALID !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_full: got wr_ready=%b level=%0d rd_valid=%b, required 0 259 1",
                     WR_READY, LEVEL, RD_VALID);
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0, pushed, popped, rdata);
        tests_run++;
        exp_w = (sb.size() != 0) ? sb.pop_front() : 'x;
        if (popped !== 1'b1 || rdata !== exp_w) begin
            tests_failed++; $display("FAIL fill_pop: got pop=%b data=%h, required 1 %h", popped, rdata, exp_w);
        end
        for (int i = 1; i <= 3; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0, pushed, popped, rdata);
            if (WR_READY === 1'b1 && ready_at < 0) ready_at = i;
        end
        tests_run++;
        if (ready_at < 0) begin
            tests_failed++; $display("FAIL fill_ready_return: WR_READY still 0 after 3 cycles, required 1");
        end
        while (sb.size() != 0 && cyc < 400) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0, pushed, popped, rdata);
            cyc++;
            if (popped) begin
                tests_run++;
                exp_w = sb.pop_front();
                if (rdata !== exp_w) begin
                    tests_failed++; $display("FAIL fill_drain: got %h, required %h", rdata, exp_w);
                end
            end
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0, pushed, popped, rdata);
        tests_run++;
        if (sb.size() != 0 || LEVEL !== '0 || RD_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_empty: got %0d pending level=%0d rd_valid=%b, required 0 0 0",
                     sb.size(), LEVEL, RD_VALID);
        end
    endtask

    task automatic test_wrap();
        logic          pushed, popped, wv, rr;
        logic [DW-1:0] rdata, exp_w, wd;
        int n_push = 0, n_pop = 0, cyc = 0, collisions = 0;
        while (n_pop < 600 && cyc < 5000) begin
            wv = (n_push < 600) && ($urandom_range(0, 3) != 0);
            rr = ((cyc % 200) < 120) ? ($urandom_range(0, 2) != 0) : 1'b0;
            wd = {$urandom, $urandom};
            drive_cycle(wv, wd, rr, 1'b0, pushed, popped, rdata);
            cyc++;
            if (SRAM_W_EN && SRAM_R_EN && SRAM_W_ADDR == SRAM_R_ADDR) collisions++;
            if (pushed) begin sb.push_back(wd); n_push++; end
            if (popped) begin
                n_pop++;
                tests_run++;
                exp_w = (sb.size() != 0) ? sb.pop_front() : 'x;
                if (rdata !== exp_w) begin
                    tests_failed++; $display("FAIL wrap_data: word %0d got %h, required %h", n_pop, rdata, exp_w);
                end
            end
        end
        tests_run++;
        if (n_pop != 600) begin
            tests_failed++; $display("FAIL wrap_count: got %0d words in %0d cycles, required 600", n_pop, cyc);
        end
        tests_run++;
        if (collisions != 0) begin
            tests_failed++; $display("FAIL wrap_collision: got %0d, required 0", collisions);
        end
    endtask

    task automatic test_flush();
        logic          pushed, popped;
        logic [DW-1:0] rdata, exp_w;
        int n_push = 0, n_pop = 0;
        for (int i = 0; i < 101; i++) begin
            drive_cycle(1'b1, 64'h3000_0000_0000_0000 + DW'(i), 1'b0, 1'b0, pushed, popped, rdata);
            if (pushed) begin sb.push_back(64'h3000_0000_0000_0000 + DW'(i)); n_push++; end
        end
        repeat (4) drive_cycle(1'b0, '0, 1'b0, 1'b0, pushed, popped, rdata);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, pushed, popped, rdata);
        tests_run++;
        exp_w = (sb.size() != 0) ? sb.pop_front() : 'x;
        if (n_push != 101 || popped !== 1'b1 || rdata !== exp_w) begin
            tests_failed++;
            $display("FAIL flush_setup: got pushes=%0d pop=%b data=%h, required 101 1 %h",
                     n_push, popped, rdata, exp_w);
        end
        // Flush cycle, with a push and a pop also presented.
        drive_cycle(1'b1, 64'h55, 1'b1, 1'b1, pushed, popped, rdata);
        tests_run++;
        if (LEVEL !== 9'd100 || SRAM_R_DATA_EN !== 1'b1 || WR_READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_pre: got level=%0d rden=%b wr_ready=%b, required 100 1 0",
                     LEVEL, SRAM_R_DATA_EN, WR_READY);
        end
        sb.delete();
        drive_cycle(1'b0, '0, 1'b0, 1'b0, pushed, popped, rdata);
        tests_run++;
        if (RD_VALID !== 1'b0 || LEVEL !== '0) begin
            tests_failed++;
            $display("FAIL flush_post: got rd_valid=%b level=%0d, required 0 0", RD_VALID, LEVEL);
        end
        drive_cycle(1'b1, 64'hAA, 1'b1, 1'b0, pushed, popped, rdata);
        if (pushed) sb.push_back(64'hAA);
        for (int k = 0; k < 10; k++) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0, pushed, popped, rdata);
            if (popped) begin
                n_pop++;
                tests_run++;
                exp_w = (sb.size() != 0) ? sb.pop_front() : 'x;
                if (rdata !== exp_w) begin
                    tests_failed++; $display("FAIL flush_first_word: got %h, required %h", rdata, exp_w);
                end
            end
        end
        tests_run++;
        if (n_pop != 1) begin
            tests_failed++; $display("FAIL flush_word_count: got %0d words, required 1", n_pop);
        end
    endtask

    task automatic test_srst_mid();
        logic          pushed, popped;
        logic [DW-1:0] rdata, exp_w;
        int n_pop = 0;
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, DW'(i), 1'b0, 1'b0, pushed, popped, rdata);
        @(negedge CLK);
        SRST = 1'b1; WR_VALID = 1'b1;
        #1;
        tests_run++;
        if (WR_READY !== 1'b0) begin
            tests_failed++; $display("FAIL srst_wr_ready: got %b during reset, required 0", WR_READY);
        end
        @(negedge CLK);
        SRST = 1'b0; WR_VALID = 1'b0;
        #1;
        tests_run++;
        if (LEVEL !== '0 || RD_VALID !== 1'b0 || WR_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL srst_cleared: got level=%0d rd_valid=%b wr_ready=%b, required 0 0 1",
                     LEVEL, RD_VALID, WR_READY);
        end
        sb.delete();
        drive_cycle(1'b1, 64'h77, 1'b1, 1'b0, pushed, popped, rdata);
        if (pushed) sb.push_back(64'h77);
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0, pushed, popped, rdata);
            if (popped) begin
                n_pop++;
                tests_run++;
                exp_w = (sb.size() != 0) ? sb.pop_front() : 'x;
                if (rdata !== exp_w) begin
                    tests_failed++; $display("FAIL srst_first_word: got %h, required %h", rdata, exp_w);
                end
            end
        end
        tests_run++;
        if (n_pop != 1) begin
            tests_failed++; $display("FAIL srst_word_count: got %0d words, required 1", n_pop);
        end
    endtask

    initial begin
        SRST = 1'b1; WR_VALID = 1'b0; RD_READY = 1'b0; FLUSH = 1'b0; WR_DATA = '0;
        test_reset();
        test_single();
        test_stream();
        test_fill();
        test_wrap();
        test_flush();
        test_srst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dma_sram_cache_ctrl.md
# dma_sram_cache_ctrl

Flow controller for the DMA channel's 256 x 64 two-port SRAM cache. Presents a valid/ready FIFO interface to the DMA read engine (producer) and write engine (consumer), generates all SRAM write/read addresses and enables, and absorbs the SRAM's two-cycle pipelined read latency with a small output buffer so the consumer sees one word per cycle sustained. It sits between the DMA engines and the SRAM cache instance; the SRAM's R_DATA_ARST_N and R_DATA_SRST_N are tied high at integration.

## Interface

Parameters:
- DATA_WIDTH, 64, word width; matches the SRAM.
- ADDR_WIDTH, 8, SRAM address width; depth = 2**ADDR_WIDTH = 256.

Ports:
- CLK  in  1  single clock; also drives the SRAM CLK.
- SRST  in  1  synchronous, active-high reset.
- WR_VALID  in  1  producer word valid.
- WR_READY  out  1  controller can accept a word.
- WR_DATA  in  DATA_WIDTH  producer word.
- RD_VALID  out  1  consumer word valid.
- RD_READY  in  1  consumer accepts word.
- RD_DATA  out  DATA_WIDTH  consumer word.
- FLUSH  in  1  synchronous discard of all contents.
- LEVEL  out  ADDR_WIDTH+1  words accepted and not yet popped, 0..259.
- SRAM_W_DATA  out  DATA_WIDTH  to SRAM W_DATA.
- SRAM_W_ADDR  out  ADDR_WIDTH  to SRAM W_ADDR.
- SRAM_W_EN  out  1  to SRAM W_EN.
- SRAM_R_ADDR  out  ADDR_WIDTH  to SRAM R_ADDR.
- SRAM_R_EN  out  1  to SRAM R_EN.
- SRAM_R_DATA_EN  out  1  to SRAM R_DATA_EN.
- SRAM_R_DATA  in  DATA_WIDTH  from SRAM R_DATA.

## Operation

- Write: push = WR_VALID & WR_READY. In the same cycle, SRAM_W_EN = push, SRAM_W_ADDR = wptr, SRAM_W_DATA = WR_DATA (combinational pass-through). wptr increments on push and wraps 255 -> 0.
- ram_count is the number of words written and not yet read-issued. WR_READY = (ram_count != 256) & ~FLUSH & ~SRST.
- Read issue: issue = (ram_count != 0) & (inflight + buf_count < 3). SRAM_R_EN = issue, SRAM_R_ADDR = rptr. rptr increments on issue and wraps.
- Read pipeline (2-bit valid shift register, states per stage IDLE/BUSY): stage 1 = address registered in the SRAM; SRAM_R_DATA_EN = stage1 valid. Stage 2 = SRAM_R_DATA valid; word is written into the output buffer at the end of that cycle.
- Output buffer: 3-entry FIFO. RD_VALID = buf_count != 0, RD_DATA = head. pop = RD_VALID & RD_READY. Credit rule guarantees it never overflows.
- ram_count: +1 on push, -1 on issue, unchanged on both. LEVEL = ram_count + inflight + buf_count.
- Address collision is impossible: a read is issued only when ram_count > 0, and raddr == waddr only at ram_count == 256, when no push is possible.
- FLUSH: pointers, counts, pipeline valids, and buffer are cleared at the clock edge. A push or pop presented in the same cycle is ignored. In-flight SRAM data is discarded.

## Timing

- Reset values (during SRST and the first cycle after): WR_READY 0 during SRST and 1 the cycle after; RD_VALID 0; LEVEL 0; SRAM_W_EN, SRAM_R_EN, SRAM_R_DATA_EN 0; SRAM_W_ADDR and SRAM_R_ADDR 0.
- SRST mid-transfer behaves identically to FLUSH, plus WR_READY is held low.
- Latency: push in cycle t into an empty controller gives SRAM_R_EN at t+1, SRAM_R_DATA_EN at t+2, SRAM_R_DATA valid at t+3, and RD_VALID at t+4.
- Throughput: 1 push/cycle and 1 pop/cycle sustained with RD_READY held high. A consumer stall of any length loses no data.
- Full: exactly 256 pushes are accepted with no pops and no issue slots. While the output buffer has room, up to 3 additional words are accepted beyond that (ram drains into the buffer), so LEVEL reaches a maximum of 259.

## Configuration

- DMA_SRAM_CACHE_CTRL_WATERMARK_EN defined: adds parameters AF_THRESH (default 240) and AE_THRESH (default 8), and registered outputs ALMOST_FULL (ram_count >= AF_THRESH) and ALMOST_EMPTY (LEVEL <= AE_THRESH). Both reset to ALMOST_FULL = 0 and ALMOST_EMPTY = 1, and update one cycle after the count changes.
- Not defined: the parameters and ports are absent and there is no threshold logic.

## Structure

- Shared package dma_sram_cache_pkg: DATA_WIDTH, ADDR_WIDTH, DEPTH = 256, LEVEL_WIDTH = 9, OUT_BUF_DEPTH = 3, SRAM_RD_LATENCY = 2.
- One sub-module: dma_sram_cache_out_buf, the 3-entry output FIFO with valid/ready on its output side.
- The SRAM itself is instantiated at the level above, not inside this block.

## Test plan

- Single word: push 0x0123_4567_89AB_CDEF at cycle t -> RD_VALID at t+4 with that data; LEVEL goes 1, then 0 after the pop.
- Streaming: 1000 incrementing words with RD_READY held high -> in-order output, no bubbles after the first word, LEVEL <= 5 throughout.
- Fill: RD_READY = 0, push continuously -> exactly 259 accepted, WR_READY drops, LEVEL = 259. Then pop one -> WR_READY returns within 3 cycles.
- Wrap: push and pop 600 words with a random RD_READY pattern -> data in order across two pointer wraps, no collisions.
- FLUSH asserted with LEVEL = 100 and a read in flight -> next cycle RD_VALID = 0, LEVEL = 0. A subsequent push of 0xAA appears as the first output word.
- Watermark build: with AF_THRESH = 240, ALMOST_FULL rises the cycle after the 240th word resident in the SRAM.
